// File: rtl/serial_add_sequencer.sv
// Bit-serial adder/subtractor: one full adder processes the operands LSB first,
// one bit per clock, then reports the result together with N/Z/C/V flags.

module serial_add_sequencer_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p_s;
  logic g_s;
  logic t_s;

  assign p_s  = a ^ b;
  assign g_s  = a & b;
  assign t_s  = p_s & cin;
  assign sum  = p_s ^ cin;
  assign cout = g_s | t_s;
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_v_q, flag_v_d;

  logic             fa_sum_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] res_next_s;

  serial_add_sequencer_fa u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  assign res_next_s = {fa_sum_s, res_q[WIDTH-1:1]};

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = res_next_s;
        carry_d = fa_cout_s;
        busy_d  = 1'b1;
        if (cnt_q == CNT_LAST) begin
          // MSB cycle: carry_q is the carry into the sign bit, so V is formed here.
          cnt_d    = cnt_q;
          done_d   = 1'b1;
          flag_n_d = fa_sum_s;
          flag_z_d = (res_next_s == '0);
          flag_c_d = fa_cout_s;
          flag_v_d = carry_q ^ fa_cout_s;
          state_d  = DONE;
        end else begin
          cnt_d    = cnt_q + CNT_ONE;
          state_d  = RUN;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b1;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign flag_n = flag_n_q;
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign flag_v = flag_v_q;
endmodule
